// File: rtl/boot_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | boot_pkg : loader state encoding and stream framing constants  r1.0 |
// +--------------------------------------------------------------------+
package boot_pkg;

  typedef enum logic [2:0] {
    LEN_LO = 3'd0,
    LEN_HI = 3'd1,
    DATA   = 3'd2,
    WRITE  = 3'd3,
    CHECK  = 3'd4,
    RUN    = 3'd5,
    ERROR  = 3'd6
  } boot_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;

endpackage
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | word_assembler : little-endian byte-to-word packer             r1.0 |
// +--------------------------------------------------------------------+
module word_assembler
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic [1:0]  count,
  output logic [31:0] word,
  output logic        word_full
);

  localparam logic [1:0] c_last = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  r_count;
  logic [31:0] r_word;
  logic        r_full;

  // Shifting in from the top leaves the first byte in bits [7:0] after four accepts.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= 2'd0;
      r_word  <= 32'd0;
      r_full  <= 1'b0;
    end else begin
      r_full <= accept && (r_count == c_last);
      if (accept) begin
        r_count <= r_count + 2'd1;
        r_word  <= {data, r_word[31:8]};
      end
    end
  end

  assign count     = r_count;
  assign word      = r_word;
  assign word_full = r_full;

endmodule
`default_nettype wire

// File: rtl/boot_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | boot_loader : streams a checksummed image into imem, starts core r1.0|
// +--------------------------------------------------------------------+
module boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic              imem_wren,
  output logic              cpu_rst,
  output logic              cpu_start,
  output logic              done,
  output logic              err
);

  localparam logic [16:0] c_max_len  = 17'(MAX_WORDS);
  localparam logic [1:0]  c_last_byte = 2'(BYTES_PER_WORD - 1);

  boot_state_t       r_state;
  logic [15:0]       r_len;
  logic [ADDR_W-1:0] r_idx;
  logic [7:0]        r_xsum;

  logic        w_accept;
  logic [1:0]  w_count;
  logic [31:0] w_word;
  logic        w_full;
  logic [15:0] w_len_full;
  logic        w_last_idx;

  assign byte_ready = (r_state == LEN_LO) || (r_state == LEN_HI) ||
                      (r_state == DATA)   || (r_state == CHECK);
  assign w_accept   = byte_valid && byte_ready;
  assign w_len_full = {byte_data, r_len[7:0]};
  assign w_last_idx = (16'(r_idx) == (r_len - 16'd1));

  word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (r_state == LEN_LO),
    .accept    (w_accept && (r_state == DATA)),
    .data      (byte_data),
    .count     (w_count),
    .word      (w_word),
    .word_full (w_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LEN_LO;
      r_len   <= 16'd0;
      r_idx   <= '0;
      r_xsum  <= 8'd0;
    end else begin
      case (r_state)
        LEN_LO: begin
          r_idx  <= '0;
          r_xsum <= 8'd0;
          if (w_accept) begin
            r_len[7:0] <= byte_data;
            r_state    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (w_accept) begin
            r_len <= w_len_full;
            if ({1'b0, w_len_full} > c_max_len) r_state <= ERROR;
            else if (w_len_full == 16'd0)       r_state <= CHECK;
            else                                r_state <= DATA;
          end
        end
        DATA: begin
          if (w_accept) begin
            r_xsum <= r_xsum ^ byte_data;
            if (w_count == c_last_byte) r_state <= WRITE;
          end
        end
        WRITE: begin
          r_idx   <= r_idx + 1'b1;
          r_state <= w_last_idx ? CHECK : DATA;
        end
        CHECK: begin
          if (w_accept) r_state <= (byte_data == r_xsum) ? RUN : ERROR;
        end
        RUN:     r_state <= RUN;
        ERROR:   r_state <= ERROR;
        default: r_state <= ERROR;
      endcase
    end
  end

  // The assembler's one-cycle full flag coincides exactly with the WRITE state.
  assign imem_wren = w_full;
  assign imem_addr = r_idx;
  assign imem_data = (r_state == WRITE) ? w_word : 32'd0;
  assign cpu_rst   = (r_state != RUN);
  assign cpu_start = (r_state == RUN);
  assign done      = (r_state == RUN);
  assign err       = (r_state == ERROR);

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_boot_loader : directed self-checking bench for boot_loader  r1.0 |
// +--------------------------------------------------------------------+
module tb_boot_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'd0;
  logic              byte_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              imem_wren;
  logic              cpu_rst;
  logic              cpu_start;
  logic              done;
  logic              err;

  int total  = 0;
  int passed = 0;
  bit gaps   = 1'b0;
  int          wr_addr[$];
  logic [31:0] wr_data[$];

  boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .imem_wren  (imem_wren),
    .cpu_rst    (cpu_rst),
    .cpu_start  (cpu_start),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_wren) begin
      wr_addr.push_back(int'(imem_addr));
      wr_data.push_back(imem_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, byte_ready, 1);
    check({tag, "_wren"},  imem_wren,  0);
    check({tag, "_addr"},  imem_addr,  0);
    check({tag, "_data"},  imem_data,  0);
    check({tag, "_cpurst"}, cpu_rst,   1);
    check({tag, "_start"}, cpu_start,  0);
    check({tag, "_done"},  done,       0);
    check({tag, "_err"},   err,        0);
  endtask

  // Presents one byte and returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] b);
    int n;
    if (gaps) begin
      n = $urandom_range(0, 3);
      repeat (n) @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      total++;
      $error("FAIL send_timeout: observed ready=0 expected ready=1 for byte 0x%0h", b);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int k);
    send(w[7:0]);
    send(w[15:8]);
    send(w[23:16]);
    send(w[31:24]);
    check($sformatf("w%0d_wren", k),  imem_wren,  1);
    check($sformatf("w%0d_addr", k),  imem_addr,  k);
    check($sformatf("w%0d_data", k),  imem_data,  w);
    check($sformatf("w%0d_ready", k), byte_ready, 0);
  endtask

  // Payload XOR: 13^00^00^00^93^00^10^00 = 0x90.
  task automatic stream_n2(input logic [7:0] csum);
    send(8'h02);
    send(8'h00);
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0093, 1);
    send(csum);
  endtask

  task automatic check_writes_n2(input string tag);
    @(negedge clk);
    check({tag, "_nwr"}, wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check({tag, "_a0"}, wr_addr[0], 0);
      check({tag, "_d0"}, wr_data[0], 32'h0000_0013);
      check({tag, "_a1"}, wr_addr[1], 1);
      check({tag, "_d1"}, wr_data[1], 32'h0010_0093);
    end
  endtask

  task automatic check_run(input string tag);
    check({tag, "_done"},   done,       1);
    check({tag, "_cpurst"}, cpu_rst,    0);
    check({tag, "_start"},  cpu_start,  1);
    check({tag, "_err"},    err,        0);
    check({tag, "_ready"},  byte_ready, 0);
  endtask

  initial begin
    // Good N=2 image
    do_reset();
    check_reset("rst1");
    wr_addr.delete(); wr_data.delete();
    stream_n2(8'h90);
    check_run("t1");
    check_writes_n2("t1");
    repeat (3) @(negedge clk);
    check("t1_hold_done", done, 1);

    // Bad checksum
    do_reset();
    check_reset("rst2");
    wr_addr.delete(); wr_data.delete();
    stream_n2(8'h81);
    check("t2_err",    err,        1);
    check("t2_cpurst", cpu_rst,    1);
    check("t2_start",  cpu_start,  0);
    check("t2_done",   done,       0);
    check_writes_n2("t2");
    repeat (3) @(negedge clk);
    check("t2_ready_after", byte_ready, 0);
    check("t2_err_sticky",  err,        1);

    // Empty image
    do_reset();
    wr_addr.delete(); wr_data.delete();
    send(8'h00);
    send(8'h00);
    check("t3_ready_check", byte_ready, 1);
    send(8'h00);
    check_run("t3");
    @(negedge clk);
    check("t3_nwr", wr_addr.size(), 0);

    // Oversize length 0x0101
    do_reset();
    wr_addr.delete(); wr_data.delete();
    send(8'h01);
    send(8'h01);
    check("t4_err",    err,        1);
    check("t4_ready",  byte_ready, 0);
    check("t4_cpurst", cpu_rst,    1);
    @(negedge clk);
    check("t4_nwr", wr_addr.size(), 0);

    // N=2 image with random valid gaps
    do_reset();
    wr_addr.delete(); wr_data.delete();
    gaps = 1'b1;
    stream_n2(8'h90);
    check_run("t5");
    check_writes_n2("t5");
    gaps = 1'b0;

    // Reset mid-word, then a full reload
    do_reset();
    wr_addr.delete(); wr_data.delete();
    send(8'h02);
    send(8'h00);
    send_word(32'h0000_0013, 0);
    send(8'h93);
    send(8'h00);
    do_reset();
    check_reset("t6_rst");
    @(negedge clk);
    check("t6_nwr_partial", wr_addr.size(), 1);
    wr_addr.delete(); wr_data.delete();
    stream_n2(8'h90);
    check_run("t6");
    check_writes_n2("t6");

    // Reset out of RUN
    do_reset();
    check_reset("rst_run");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
